slot_game_sequencer: RTL and testbench

- Game-level controller for the slot machine.
- Owns the credit register and gates the free-running reel counter via spin_en.
- Stops the three 2-bit reels one at a time, evaluates the result and pays out.
- Sits between board inputs (SW/KEY) and the reel counter; drives credit and result LEDs.

---
 rtl/slot_pkg.sv | 33 +++
 rtl/slot_if.sv | 27 ++
 rtl/slot_key_edge.sv | 29 ++
 rtl/slot_game_sequencer.sv | 178 +++++++++++++++++
 tb/tb_slot_game_sequencer.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/slot_pkg.sv
// Shared types and constants for the slot machine game controller.
package slot_pkg;

  localparam int CREDIT_W   = 5;
  localparam int CREDIT_MAX = 31;
  localparam int REEL_W     = 2;
  localparam int REELS_W    = 3 * REEL_W;

  // Reel field positions inside the packed {A,B,C} reel word
  localparam int REEL_A_LSB = 2 * REEL_W;
  localparam int REEL_B_LSB = REEL_W;
  localparam int REEL_C_LSB = 0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SPIN   = 3'd1,
    S_STOP_A = 3'd2,
    S_STOP_B = 3'd3,
    S_STOP_C = 3'd4,
    S_EVAL   = 3'd5,
    S_PAY    = 3'd6
  } state_t;

  // Credit addition that clamps at CREDIT_MAX instead of wrapping
  function automatic logic [CREDIT_W-1:0] sat_add(input logic [CREDIT_W-1:0] a,
                                                  input logic [CREDIT_W-1:0] b);
    logic [CREDIT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > (CREDIT_W+1)'(CREDIT_MAX)) return CREDIT_W'(CREDIT_MAX);
    else                                   return sum[CREDIT_W-1:0];
  endfunction

endpackage

// File: rtl/slot_if.sv
// Board-side signal bundle of the game controller: switches, key, reel
// counter value in; reel enable, credit and result indicators out.
interface slot_if;
  import slot_pkg::*;

  logic                load_en;
  logic                cash_out;
  logic [2:0]          money_in;
  logic                start_n;
  logic [REELS_W-1:0]  reels;
  logic                spin_en;
  logic [CREDIT_W-1:0] credits;
  logic [REELS_W-1:0]  result;
  logic                win;
  logic                busy;

  modport master (
    output load_en, cash_out, money_in, start_n, reels,
    input  spin_en, credits, result, win, busy
  );

  modport slave (
    input  load_en, cash_out, money_in, start_n, reels,
    output spin_en, credits, result, win, busy
  );

endinterface

// File: rtl/slot_key_edge.sv
// Two-flop synchroniser plus falling-edge detector for an active-low key.
// Produces a single-cycle press pulse however long the key is held.
module slot_key_edge (
  input  logic clk,
  input  logic i_rst_b,
  input  logic i_key_n,
  output logic o_press
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  // Synchronise the key and keep one older sample for edge detection
  always_ff @(posedge clk) begin
    if (!i_rst_b) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_press = r_prev & ~r_sync2;

endmodule

// File: rtl/slot_game_sequencer.sv
// Game-level slot machine controller: owns credits, gates the reel counter,
// stops reels A, B, C in turn, evaluates and pays out.
// Optional macro SLOT_PAIR_PAY_EN: a pair (exactly two equal reels) also
// wins and pays 1 credit; without it only three of a kind pays.
//
// state    | meaning
// IDLE     | accept cash_out / load_en / start press
// SPIN     | reels running, waiting SPIN_CYCLES
// STOP_A   | reels running, waiting STOP_GAP then latch reel A
// STOP_B   | waiting STOP_GAP then latch reel B
// STOP_C   | waiting STOP_GAP then latch reel C, reels stop
// EVAL     | decide win from latched result
// PAY      | add payout on a win, return to IDLE
module slot_game_sequencer
  import slot_pkg::*;
#(
  parameter int SPIN_CYCLES = 25000000,
  parameter int STOP_GAP    = 12500000,
  parameter int PAYOUT      = 2,
  parameter int CNT_W       = 26
) (
  input  logic   clk,
  input  logic   Clear_b,
  slot_if.slave  sg
);

  localparam logic [CNT_W-1:0]    SPIN_LOAD = CNT_W'(SPIN_CYCLES - 1);
  localparam logic [CNT_W-1:0]    GAP_LOAD  = CNT_W'(STOP_GAP - 1);
  localparam logic [CREDIT_W-1:0] PAY_AMT   = CREDIT_W'(PAYOUT);

  state_t               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [CREDIT_W-1:0]  r_credits, w_credits_nxt;
  logic [REELS_W-1:0]   r_result, w_result_nxt;
  logic                 r_win, w_win_nxt;

  logic                 w_press;
  logic                 w_cnt_done;
  logic [REEL_W-1:0]    w_a, w_b, w_c;
  logic                 w_triple;
  logic [CREDIT_W-1:0]  w_pay_amt;

  slot_key_edge u_start_key (
    .clk     (clk),
    .i_rst_b (Clear_b),
    .i_key_n (sg.start_n),
    .o_press (w_press)
  );

  assign w_cnt_done = (r_cnt == '0);
  assign w_a        = r_result[REEL_A_LSB +: REEL_W];
  assign w_b        = r_result[REEL_B_LSB +: REEL_W];
  assign w_c        = r_result[REEL_C_LSB +: REEL_W];
  assign w_triple   = (w_a == w_b) && (w_b == w_c);

`ifdef SLOT_PAIR_PAY_EN
  logic r_pair, w_pair_nxt;
  logic w_pair;

  assign w_pair    = !w_triple && ((w_a == w_b) || (w_b == w_c) || (w_a == w_c));
  assign w_pay_amt = r_pair ? CREDIT_W'(1) : PAY_AMT;

  // Remember which kind of win EVAL found so PAY knows the amount
  always_ff @(posedge clk) begin
    if (!Clear_b) r_pair <= 1'b0;
    else          r_pair <= w_pair_nxt;
  end
`else
  assign w_pay_amt = PAY_AMT;
`endif

  // State, delay counter, credit and result registers
  always_ff @(posedge clk) begin
    if (!Clear_b) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_credits <= '0;
      r_result  <= '0;
      r_win     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_credits <= w_credits_nxt;
      r_result  <= w_result_nxt;
      r_win     <= w_win_nxt;
    end
  end

  // Next-state and datapath updates; every register holds unless told otherwise
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_credits_nxt = r_credits;
    w_result_nxt  = r_result;
    w_win_nxt     = r_win;
`ifdef SLOT_PAIR_PAY_EN
    w_pair_nxt    = r_pair;
`endif

    case (r_state)
      S_IDLE: begin
        if (sg.cash_out) begin
          w_credits_nxt = '0;
        end else if (sg.load_en) begin
          w_credits_nxt = {2'b00, sg.money_in};
        end else if (w_press && (r_credits != '0)) begin
          w_credits_nxt = r_credits - CREDIT_W'(1);
          w_win_nxt     = 1'b0;
          w_cnt_nxt     = SPIN_LOAD;
          w_state_nxt   = S_SPIN;
        end
      end

      S_SPIN: begin
        if (w_cnt_done) begin
          w_cnt_nxt   = GAP_LOAD;
          w_state_nxt = S_STOP_A;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      S_STOP_A: begin
        if (w_cnt_done) begin
          w_result_nxt[REEL_A_LSB +: REEL_W] = sg.reels[REEL_A_LSB +: REEL_W];
          w_cnt_nxt   = GAP_LOAD;
          w_state_nxt = S_STOP_B;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      S_STOP_B: begin
        if (w_cnt_done) begin
          w_result_nxt[REEL_B_LSB +: REEL_W] = sg.reels[REEL_B_LSB +: REEL_W];
          w_cnt_nxt   = GAP_LOAD;
          w_state_nxt = S_STOP_C;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      S_STOP_C: begin
        if (w_cnt_done) begin
          w_result_nxt[REEL_C_LSB +: REEL_W] = sg.reels[REEL_C_LSB +: REEL_W];
          w_state_nxt = S_EVAL;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end

      S_EVAL: begin
`ifdef SLOT_PAIR_PAY_EN
        w_win_nxt  = w_triple || w_pair;
        w_pair_nxt = w_pair;
`else
        w_win_nxt  = w_triple;
`endif
        w_state_nxt = S_PAY;
      end

      S_PAY: begin
        if (r_win) w_credits_nxt = sat_add(r_credits, w_pay_amt);
        w_state_nxt = S_IDLE;
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign sg.spin_en = (r_state == S_SPIN)   || (r_state == S_STOP_A) ||
                      (r_state == S_STOP_B) || (r_state == S_STOP_C);
  assign sg.busy    = (r_state != S_IDLE);
  assign sg.credits = r_credits;
  assign sg.result  = r_result;
  assign sg.win     = r_win;

endmodule

// File: tb/tb_slot_game_sequencer.sv
// Directed bench for slot_game_sequencer with a queue of expected game outcomes.
module tb_slot_game_sequencer;
  import slot_pkg::*;

  localparam int SPIN_CYCLES = 4;
  localparam int STOP_GAP    = 2;
  localparam int PAYOUT      = 2;
  localparam int GAME_BUSY   = SPIN_CYCLES + 3*STOP_GAP + 2;
  localparam int GAME_SPIN   = SPIN_CYCLES + 3*STOP_GAP;

  typedef struct {
    logic [5:0] result;
    logic       win;
    int         credits;
  } exp_t;

  logic clk = 1'b0;
  logic Clear_b = 1'b0;
  slot_if sg();

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   m_credits = 0;

  slot_game_sequencer #(
    .SPIN_CYCLES (SPIN_CYCLES),
    .STOP_GAP    (STOP_GAP),
    .PAYOUT      (PAYOUT),
    .CNT_W       (26)
  ) dut (
    .clk     (clk),
    .Clear_b (Clear_b),
    .sg      (sg.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  function automatic int pay_for(input logic [5:0] r);
    logic [1:0] a, b, c;
    a = r[5:4];
    b = r[3:2];
    c = r[1:0];
    if (a == b && b == c) return PAYOUT;
`ifdef SLOT_PAIR_PAY_EN
    if (a == b || b == c || a == c) return 1;
`endif
    return 0;
  endfunction

  task automatic step(inout int nb, inout int ns);
    tick();
    if (sg.busy === 1'b1) nb++;
    if (sg.spin_en === 1'b1) ns++;
  endtask

  task automatic load(input int v);
    sg.load_en  = 1'b1;
    sg.money_in = 3'(v);
    tick();
    sg.load_en  = 1'b0;
    m_credits   = v;
    check("load_credits", 32'(sg.credits), 32'(m_credits));
  endtask

  // One full game: press, optional mid-game disturbance, wait, score
  task automatic play_game(input logic [5:0] rv, input bit hold, input bit disturb);
    exp_t e;
    int   pay, nb, ns, budget, deb;
    sg.reels = rv;
    tick();
    sg.start_n = 1'b0;
    tick();
    tick();
    check("pre_debit_credits", 32'(sg.credits), 32'(m_credits));
    check("pre_press_busy", 32'(sg.busy), 32'd0);
    tick();
    deb = m_credits - 1;
    check("debit_credits", 32'(sg.credits), 32'(deb));
    check("press_busy", 32'(sg.busy), 32'd1);
    check("press_spin_en", 32'(sg.spin_en), 32'd1);
    check("press_win_clr", 32'(sg.win), 32'd0);
    if (!hold) sg.start_n = 1'b1;

    pay = pay_for(rv);
    e.result  = rv;
    e.win     = (pay != 0);
    e.credits = (deb + pay > CREDIT_MAX) ? CREDIT_MAX : deb + pay;
    sb.push_back(e);
    m_credits = e.credits;

    nb = 1;
    ns = 1;
    if (disturb) begin
      step(nb, ns);
      sg.cash_out = 1'b1;
      sg.load_en  = 1'b1;
      sg.money_in = 3'd7;
      sg.start_n  = 1'b0;
      step(nb, ns);
      step(nb, ns);
      check("busy_ignore_credits", 32'(sg.credits), 32'(deb));
      step(nb, ns);
      sg.cash_out = 1'b0;
      sg.load_en  = 1'b0;
      sg.start_n  = 1'b1;
    end
    budget = 0;
    while (sg.busy === 1'b1 && budget < 200) begin
      step(nb, ns);
      budget++;
    end
    check("game_end_busy", 32'(sg.busy), 32'd0);
    check("busy_cycles", 32'(nb), 32'(GAME_BUSY));
    check("spin_cycles", 32'(ns), 32'(GAME_SPIN));
    e = sb.pop_front();
    check("result", 32'(sg.result), 32'(e.result));
    check("win", 32'(sg.win), 32'(e.win));
    check("credits", 32'(sg.credits), 32'(e.credits));
  endtask

  initial begin
    sg.load_en  = 1'b0;
    sg.cash_out = 1'b0;
    sg.money_in = 3'd0;
    sg.start_n  = 1'b1;
    sg.reels    = 6'd0;

    // Reset values
    tick();
    tick();
    check("rst_busy", 32'(sg.busy), 32'd0);
    check("rst_spin_en", 32'(sg.spin_en), 32'd0);
    check("rst_credits", 32'(sg.credits), 32'd0);
    check("rst_result", 32'(sg.result), 32'd0);
    check("rst_win", 32'(sg.win), 32'd0);
    Clear_b = 1'b1;
    tick();

    // Load 5, triple win game, then a pair/no-win game
    load(5);
    play_game(6'b010101, 1'b0, 1'b0);
    play_game(6'b010110, 1'b0, 1'b0);

    // Climb to 30 with triples, then saturate at 31 twice
    while (m_credits < 30) play_game(6'b111111, 1'b0, 1'b0);
    check("at_30", 32'(sg.credits), 32'd30);
    play_game(6'b000000, 1'b0, 1'b0);
    check("sat_31", 32'(sg.credits), 32'd31);
    play_game(6'b101010, 1'b0, 1'b0);
    check("sat_31_again", 32'(sg.credits), 32'd31);

    // cash_out, load_en and a second press while busy are all ignored
    play_game(6'b000110, 1'b0, 1'b1);
    tick();
    check("no_queued_press", 32'(sg.busy), 32'd0);

    // cash_out wins over load_en in IDLE
    sg.cash_out = 1'b1;
    sg.load_en  = 1'b1;
    sg.money_in = 3'd7;
    tick();
    sg.cash_out = 1'b0;
    sg.load_en  = 1'b0;
    m_credits   = 0;
    check("cash_out_prio", 32'(sg.credits), 32'd0);

    // Press with zero credits does nothing
    sg.start_n = 1'b0;
    tick();
    tick();
    tick();
    tick();
    sg.start_n = 1'b1;
    check("zero_press_busy", 32'(sg.busy), 32'd0);
    check("zero_press_spin", 32'(sg.spin_en), 32'd0);
    check("zero_press_credits", 32'(sg.credits), 32'd0);
    tick();

    // Held key yields exactly one debit
    load(3);
    play_game(6'b101010, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    check("hold_busy", 32'(sg.busy), 32'd0);
    check("hold_credits", 32'(sg.credits), 32'(m_credits));
    sg.start_n = 1'b1;
    tick();
    tick();
    tick();
    check("hold_release_credits", 32'(sg.credits), 32'(m_credits));

    // Reset during STOP_B aborts with no payout or refund
    sg.reels   = 6'b010101;
    sg.start_n = 1'b0;
    tick();
    tick();
    tick();
    sg.start_n = 1'b1;
    check("abort_game_started", 32'(sg.busy), 32'd1);
    for (int i = 0; i < SPIN_CYCLES + STOP_GAP; i++) tick();
    check("abort_still_spin", 32'(sg.spin_en), 32'd1);
    Clear_b = 1'b0;
    tick();
    check("abort_busy", 32'(sg.busy), 32'd0);
    check("abort_credits", 32'(sg.credits), 32'd0);
    check("abort_result", 32'(sg.result), 32'd0);
    check("abort_win", 32'(sg.win), 32'd0);
    check("abort_spin_en", 32'(sg.spin_en), 32'd0);
    Clear_b   = 1'b1;
    m_credits = 0;
    tick();

    // Recovery game after reset
    load(7);
    play_game(6'b011001, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
